rv32im_decode_exec_slice: RTL and testbench
===========================================

Name: rv32im_decode_exec_slice

Overview:
Single-issue RV32IM decode + execute slice. It merges instruction decode (control unit), the integer/M-extension ALU and the branch/jump resolver. Decode, operand select, ALU and branch compare are combinational from the current instruction and operands; the results are captured in one output register bank, like an EX/MEM boundary. It sits between register-file read and the memory stage.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  synchronous active-high reset
HOLD  input  1  1 = output registers keep their value (stall)
INSTRUCTION  input  32  instruction being executed
PC  input  32  address of INSTRUCTION
RS1_DATA  input  32  rs1 value (already forwarded)
RS2_DATA  input  32  rs2 value (already forwarded)
IMMEDIATE  input  32  sign-extended immediate from external generator
IMMEDIATE_SELECT  output  3  combinational, for the immediate generator: I=000 S=001 B=010 U=011 J=100
ALU_OUT  output  32  registered ALU result or branch/jump target
BJ_SIG  output  1  registered, 1 = redirect fetch to ALU_OUT
REG_WRITE_EN  output  1  registered
RD_ADDR  output  5  registered, INSTRUCTION[11:7]
DATA_MEM_WRITE  output  3  registered {en, size}: SB=100 SH=101 SW=110
DATA_MEM_READ  output  4  registered {en, funct3}: LB=1000 LH=1001 LW=1010 LBU=1100 LHU=1101
WB_VALUE_SELECT  output  2  registered: 00 = PC+4, 01 = ALU, 10 = memory
STORE_DATA  output  32  registered RS2_DATA
PC_PLUS_4  output  32  registered PC+4

Behaviour:
- Latency is 1 cycle. All registered outputs update on posedge CLK unless HOLD=1. RESET takes priority over HOLD and zeroes every registered output (a bubble).
- ALU_SELECT (internal, 5 bits) = {funct7[0], funct7[5], funct3}:
  - ADD 00000, SUB 01000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111.
  - MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
  - FWD 01111 (result = op2).
  - Any other code gives result 0.
- op1 = PC when OP1_SEL=1, else RS1_DATA. op2 = IMMEDIATE when OP2_SEL=1, else RS2_DATA.
- Shifts use op2[4:0]. SLT is signed, SLTU unsigned.
- MULH is signed×signed upper 32 bits. MULHSU is signed op1 × unsigned op2, upper 32. MULHU is unsigned upper 32.
- Divide by zero: DIV and DIVU give 0xFFFFFFFF; REM and REMU give op1.
- Signed overflow: DIV 0x80000000 / -1 = 0x80000000; REM of the same = 0.
- DIV and REM truncate toward zero; the remainder takes the sign of the dividend.
- Decode by opcode (fields not listed are 0; IMMEDIATE_SELECT is 000 unless stated):
  - LUI 0110111: OP2=imm, FWD, IMMEDIATE_SELECT U, write, WB 01.
  - AUIPC 0010111: OP1=PC, OP2=imm, ADD, U, write, WB 01.
  - JAL 1101111: OP1=PC, OP2=imm, ADD, J, BRANCH_CTRL 1010, write, WB 00.
  - JALR 1100111: rs1+imm, ADD, I, BRANCH_CTRL 1010, write, WB 00. The target has bit 0 forced to 0.
  - BRANCH 1100011: OP1=PC, OP2=imm, ADD, B, BRANCH_CTRL {1, funct3}.
  - LOAD 0000011: rs1+imm, ADD, I, read {1, funct3}, write, WB 10.
  - STORE 0100011: rs1+imm, ADD, S, write-mem {1, funct3[1:0]}.
  - OP-IMM 0010011: OP2=imm, I, ALU_SELECT {0, funct3==101 ? funct7[5] : 0, funct3}, write, WB 01.
  - OP 0110011: register operands, ALU_SELECT {funct7[0], funct7[5], funct3}, write, WB 01.
  - Any other opcode, including 0x00000000: all controls 0 (NOP).
- Branch resolver (BRANCH_CTRL[3]=0 gives BJ=0). It always compares RS1_DATA with RS2_DATA, never the muxed operands.
  - 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU.
  - 010 unconditional (JAL/JALR).
  - 011 never taken.
- REG_WRITE_EN is not masked for rd=x0; the register file ignores x0.

Decomposition:
- Shared package rv32im_pkg holds:
  - opcode localparams;
  - ALU_SELECT, BRANCH_CTRL, IMMEDIATE_SELECT, WB_VALUE_SELECT, DATA_MEM_READ and DATA_MEM_WRITE encodings.
- One natural sub-module: rv32im_alu, the combinational ALU including M-extension. Decode, branch compare and the output register stay in the top.

Test Plan:
- RESET=1 for one posedge with ADD in flight → all registered outputs 0. Then ADD x3,x1,x2 (0x002081B3) with RS1=5, RS2=7 → next cycle ALU_OUT=12, REG_WRITE_EN=1, RD_ADDR=3, WB=01, BJ=0.
- SUB/SRA/SLT: RS1=0x80000000, RS2=1 → SUB gives 0x7FFFFFFF; SRA by 1 gives 0xC0000000; SLT gives 1; SLTU gives 0.
- M-extension:
  - MULH 0xFFFFFFFF×0xFFFFFFFF gives 0; MULHU gives 0xFFFFFFFE.
  - DIV 7/0 gives 0xFFFFFFFF; REM 7/0 gives 7.
  - DIV 0x80000000/-1 gives 0x80000000; REM gives 0; DIV -7/2 gives -3.
- Branches with PC=0x100, IMMEDIATE=0x20:
  - BEQ, RS1=RS2=9 → BJ=1, ALU_OUT=0x120.
  - BLT RS1=-1, RS2=1 → BJ=1; BLTU on the same values → BJ=0.
- JALR with RS1=0x1001, imm=4 → ALU_OUT=0x1004, BJ=1, WB=00, PC_PLUS_4=PC+4.
- Memory and control: LW (0x0040A183) → DATA_MEM_READ=1010, WB=10. SW → DATA_MEM_WRITE=110, REG_WRITE_EN=0.
- HOLD=1 keeps all registered outputs for 3 cycles while inputs change. Unknown opcode 0x0000007F → NOP outputs.

Source files
------------

// File: rtl/rv32im_pkg.sv
// Shared encodings for the RV32IM decode/execute slice: opcodes, ALU
// operation codes, branch control, immediate format select, writeback
// select, memory access codes and the decoded-control / output bundles.
package rv32im_pkg;

  localparam int XLEN = 32;

  // Major opcodes (INSTRUCTION[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU select = {funct7[0], funct7[5], funct3}
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b01000;
  localparam logic [4:0] ALU_SLL    = 5'b00001;
  localparam logic [4:0] ALU_SLT    = 5'b00010;
  localparam logic [4:0] ALU_SLTU   = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_SRA    = 5'b01101;
  localparam logic [4:0] ALU_OR     = 5'b00110;
  localparam logic [4:0] ALU_AND    = 5'b00111;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;
  localparam logic [4:0] ALU_FWD    = 5'b01111;

  // Branch control: bit 3 = branch/jump instruction, [2:0] = condition
  localparam logic [3:0] BR_NONE = 4'b0000;
  localparam logic [3:0] BR_JUMP = 4'b1010;

  // Immediate generator format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Writeback value select
  localparam logic [1:0] WB_PC4 = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  // Memory access codes: read = {en, funct3}, write = {en, size}
  localparam logic [3:0] MEM_RD_NONE = 4'b0000;
  localparam logic [2:0] MEM_WR_NONE = 3'b000;

  // Decoded control for the instruction currently in the slice
  typedef struct packed {
    logic       op1_pc;       // 1 = op1 is PC
    logic       op2_imm;      // 1 = op2 is IMMEDIATE
    logic [4:0] alu_sel;
    logic [2:0] imm_sel;
    logic [3:0] branch_ctrl;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [3:0] mem_read;
    logic [2:0] mem_write;
    logic       clear_lsb;    // JALR target has bit 0 cleared
  } ctrl_t;

  // Registered EX/MEM output bank
  typedef struct packed {
    logic [31:0] alu_out;
    logic        bj;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [2:0]  mem_write;
    logic [3:0]  mem_read;
    logic [1:0]  wb_sel;
    logic [31:0] store_data;
    logic [31:0] pc_plus_4;
  } ex_out_t;

  // Resolve a branch/jump from its control code and the raw register values
  function automatic logic branch_taken(input logic [3:0]  br,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic t;
    t = 1'b0;
    if (br[3]) begin
      case (br[2:0])
        3'b000:  t = (a == b);
        3'b001:  t = (a != b);
        3'b100:  t = ($signed(a) <  $signed(b));
        3'b101:  t = ($signed(a) >= $signed(b));
        3'b110:  t = (a <  b);
        3'b111:  t = (a >= b);
        3'b010:  t = 1'b1;
        default: t = 1'b0;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/rv32im_alu.sv
// Combinational RV32IM ALU: base integer ops, operand forward and the
// M-extension multiply/divide with RISC-V divide-by-zero/overflow rules.
module rv32im_alu
  import rv32im_pkg::*;
(
  input  logic [4:0]  alu_select,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] result
);

  logic [63:0] op1_sx, op2_sx, op1_zx, op2_zx;
  logic [63:0] mul_ss, mul_su, mul_uu;
  logic [31:0] op1_abs, op2_abs, quo_abs, rem_abs;
  logic [31:0] div_s, rem_s, div_u, rem_u;
  logic        div_zero, div_ovf;
  logic [4:0]  shamt;
  logic [63:0] unused_mul_lo;

  // Multiply/divide building blocks; divisors of zero are guarded so no X leaks
  always_comb begin
    shamt   = op2[4:0];
    op1_sx  = {{32{op1[31]}}, op1};
    op2_sx  = {{32{op2[31]}}, op2};
    op1_zx  = {32'd0, op1};
    op2_zx  = {32'd0, op2};
    mul_ss  = op1_sx * op2_sx;
    mul_su  = op1_sx * op2_zx;
    mul_uu  = op1_zx * op2_zx;

    div_zero = (op2 == 32'd0);
    div_ovf  = (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

    op1_abs = op1[31] ? (32'd0 - op1) : op1;
    op2_abs = op2[31] ? (32'd0 - op2) : op2;
    quo_abs = div_zero ? 32'd0 : (op1_abs / op2_abs);
    rem_abs = div_zero ? 32'd0 : (op1_abs % op2_abs);

    // Quotient truncates toward zero; remainder follows dividend sign
    if (div_zero)                div_s = 32'hFFFF_FFFF;
    else if (div_ovf)            div_s = 32'h8000_0000;
    else if (op1[31] ^ op2[31])  div_s = 32'd0 - quo_abs;
    else                         div_s = quo_abs;

    if (div_zero)                rem_s = op1;
    else if (div_ovf)            rem_s = 32'd0;
    else if (op1[31])            rem_s = 32'd0 - rem_abs;
    else                         rem_s = rem_abs;

    div_u = div_zero ? 32'hFFFF_FFFF : (op1 / op2);
    rem_u = div_zero ? op1 : (op1 % op2);

    unused_mul_lo = {mul_ss[31:0], mul_su[31:0]};
  end

  // Operation select; unlisted codes produce zero
  always_comb begin
    result = 32'd0;
    case (alu_select)
      ALU_ADD:    result = op1 + op2;
      ALU_SUB:    result = op1 - op2;
      ALU_SLL:    result = op1 << shamt;
      ALU_SLT:    result = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU:   result = {31'd0, op1 < op2};
      ALU_XOR:    result = op1 ^ op2;
      ALU_SRL:    result = op1 >> shamt;
      ALU_SRA:    result = 32'($signed(op1) >>> shamt);
      ALU_OR:     result = op1 | op2;
      ALU_AND:    result = op1 & op2;
      ALU_MUL:    result = mul_uu[31:0];
      ALU_MULH:   result = mul_ss[63:32];
      ALU_MULHSU: result = mul_su[63:32];
      ALU_MULHU:  result = mul_uu[63:32];
      ALU_DIV:    result = div_s;
      ALU_DIVU:   result = div_u;
      ALU_REM:    result = rem_s;
      ALU_REMU:   result = rem_u;
      ALU_FWD:    result = op2;
      default:    result = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv32im_decode_exec_slice.sv
// RV32IM decode + execute slice: decodes INSTRUCTION, selects operands,
// runs the ALU and branch compare, and captures everything in one
// EX/MEM output register bank (1-cycle latency).
//
// Stall semantics: HOLD=1 freezes the whole output bank; there is no
// valid/ready pair -- the upstream stage must hold its own inputs while
// HOLD is asserted. RESET wins over HOLD and loads a bubble (all zero).
module rv32im_decode_exec_slice
  import rv32im_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            HOLD,
  input  logic [31:0]     INSTRUCTION,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] RS1_DATA,
  input  logic [XLEN-1:0] RS2_DATA,
  input  logic [XLEN-1:0] IMMEDIATE,
  output logic [2:0]      IMMEDIATE_SELECT,
  output logic [XLEN-1:0] ALU_OUT,
  output logic            BJ_SIG,
  output logic            REG_WRITE_EN,
  output logic [4:0]      RD_ADDR,
  output logic [2:0]      DATA_MEM_WRITE,
  output logic [3:0]      DATA_MEM_READ,
  output logic [1:0]      WB_VALUE_SELECT,
  output logic [XLEN-1:0] STORE_DATA,
  output logic [XLEN-1:0] PC_PLUS_4
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  ctrl_t       ctrl;
  logic [31:0] op1, op2, alu_result;
  logic        bj_taken;
  ex_out_t     ex_d, ex_q;
  logic [9:0]  unused_instr;

  assign opcode       = INSTRUCTION[6:0];
  assign funct3       = INSTRUCTION[14:12];
  assign funct7       = INSTRUCTION[31:25];
  // rs1/rs2 fields arrive as forwarded data, not used here
  assign unused_instr = INSTRUCTION[24:15];

  // Instruction decode into the control bundle; unknown opcodes are NOPs
  always_comb begin
    ctrl = '0;
    case (opcode)
      OPC_LUI: begin
        ctrl.op2_imm   = 1'b1;
        ctrl.alu_sel   = ALU_FWD;
        ctrl.imm_sel   = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_ALU;
      end
      OPC_AUIPC: begin
        ctrl.op1_pc    = 1'b1;
        ctrl.op2_imm   = 1'b1;
        ctrl.alu_sel   = ALU_ADD;
        ctrl.imm_sel   = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_ALU;
      end
      OPC_JAL: begin
        ctrl.op1_pc      = 1'b1;
        ctrl.op2_imm     = 1'b1;
        ctrl.alu_sel     = ALU_ADD;
        ctrl.imm_sel     = IMM_J;
        ctrl.branch_ctrl = BR_JUMP;
        ctrl.reg_write   = 1'b1;
        ctrl.wb_sel      = WB_PC4;
      end
      OPC_JALR: begin
        ctrl.op2_imm     = 1'b1;
        ctrl.alu_sel     = ALU_ADD;
        ctrl.imm_sel     = IMM_I;
        ctrl.branch_ctrl = BR_JUMP;
        ctrl.reg_write   = 1'b1;
        ctrl.wb_sel      = WB_PC4;
        ctrl.clear_lsb   = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.op1_pc      = 1'b1;
        ctrl.op2_imm     = 1'b1;
        ctrl.alu_sel     = ALU_ADD;
        ctrl.imm_sel     = IMM_B;
        ctrl.branch_ctrl = {1'b1, funct3};
      end
      OPC_LOAD: begin
        ctrl.op2_imm   = 1'b1;
        ctrl.alu_sel   = ALU_ADD;
        ctrl.imm_sel   = IMM_I;
        ctrl.mem_read  = {1'b1, funct3};
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        ctrl.op2_imm   = 1'b1;
        ctrl.alu_sel   = ALU_ADD;
        ctrl.imm_sel   = IMM_S;
        ctrl.mem_write = {1'b1, funct3[1:0]};
      end
      OPC_OP_IMM: begin
        ctrl.op2_imm   = 1'b1;
        ctrl.imm_sel   = IMM_I;
        // Only SRAI distinguishes on funct7[5]; other imm bits are not funct7
        ctrl.alu_sel   = {1'b0, (funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_ALU;
      end
      OPC_OP: begin
        ctrl.alu_sel   = {funct7[0], funct7[5], funct3};
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_ALU;
      end
      default: ctrl = '0;
    endcase
  end

  // Operand select and branch resolution on the raw register values
  always_comb begin
    op1      = ctrl.op1_pc  ? PC        : RS1_DATA;
    op2      = ctrl.op2_imm ? IMMEDIATE : RS2_DATA;
    bj_taken = branch_taken(ctrl.branch_ctrl, RS1_DATA, RS2_DATA);
  end

  rv32im_alu u_alu (
    .alu_select (ctrl.alu_sel),
    .op1        (op1),
    .op2        (op2),
    .result     (alu_result)
  );

  // Next value of the output bank; HOLD recirculates the current contents
  always_comb begin
    ex_d = ex_q;
    if (!HOLD) begin
      ex_d.alu_out    = ctrl.clear_lsb ? {alu_result[31:1], 1'b0} : alu_result;
      ex_d.bj         = bj_taken;
      ex_d.reg_write  = ctrl.reg_write;
      ex_d.rd_addr    = INSTRUCTION[11:7];
      ex_d.mem_write  = ctrl.mem_write;
      ex_d.mem_read   = ctrl.mem_read;
      ex_d.wb_sel     = ctrl.wb_sel;
      ex_d.store_data = RS2_DATA;
      ex_d.pc_plus_4  = PC + 32'd4;
    end
  end

  // Output bank register; reset inserts a bubble
  always_ff @(posedge CLK) begin
    if (RESET) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign IMMEDIATE_SELECT = ctrl.imm_sel;
  assign ALU_OUT          = ex_q.alu_out;
  assign BJ_SIG           = ex_q.bj;
  assign REG_WRITE_EN     = ex_q.reg_write;
  assign RD_ADDR          = ex_q.rd_addr;
  assign DATA_MEM_WRITE   = ex_q.mem_write;
  assign DATA_MEM_READ    = ex_q.mem_read;
  assign WB_VALUE_SELECT  = ex_q.wb_sel;
  assign STORE_DATA       = ex_q.store_data;
  assign PC_PLUS_4        = ex_q.pc_plus_4;

endmodule

// File: tb/tb_rv32im_decode_exec_slice.sv
// Directed testbench for rv32im_decode_exec_slice.
module tb_rv32im_decode_exec_slice;

  logic        clk;
  logic        reset;
  logic        hold;
  logic [31:0] instruction, pc, rs1_data, rs2_data, immediate;
  logic [2:0]  immediate_select;
  logic [31:0] alu_out;
  logic        bj_sig;
  logic        reg_write_en;
  logic [4:0]  rd_addr;
  logic [2:0]  data_mem_write;
  logic [3:0]  data_mem_read;
  logic [1:0]  wb_value_select;
  logic [31:0] store_data;
  logic [31:0] pc_plus_4;

  int checks;
  int failures;

  rv32im_decode_exec_slice #(.XLEN(32)) dut (
    .CLK              (clk),
    .RESET            (reset),
    .HOLD             (hold),
    .INSTRUCTION      (instruction),
    .PC               (pc),
    .RS1_DATA         (rs1_data),
    .RS2_DATA         (rs2_data),
    .IMMEDIATE        (immediate),
    .IMMEDIATE_SELECT (immediate_select),
    .ALU_OUT          (alu_out),
    .BJ_SIG           (bj_sig),
    .REG_WRITE_EN     (reg_write_en),
    .RD_ADDR          (rd_addr),
    .DATA_MEM_WRITE   (data_mem_write),
    .DATA_MEM_READ    (data_mem_read),
    .WB_VALUE_SELECT  (wb_value_select),
    .STORE_DATA       (store_data),
    .PC_PLUS_4        (pc_plus_4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic [31:0] instr, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm);
    instruction = instr;
    pc          = p;
    rs1_data    = a;
    rs2_data    = b;
    immediate   = imm;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hold  = 1'b0;
    drive(32'h002081B3, 32'h40, 32'd5, 32'd7, 32'd0);
    tick();
    checks++;
    if ({alu_out, bj_sig, reg_write_en, rd_addr, data_mem_write, data_mem_read,
         wb_value_select, store_data, pc_plus_4} !== '0) begin
      failures++;
      $display("FAIL reset_bubble got alu=%h bj=%b we=%b rd=%0d wr=%b rd_en=%b wb=%b sd=%h pc4=%h required all zero",
               alu_out, bj_sig, reg_write_en, rd_addr, data_mem_write, data_mem_read,
               wb_value_select, store_data, pc_plus_4);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    drive(32'h002081B3, 32'h40, 32'd5, 32'd7, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'd12) begin failures++; $display("FAIL add_result got=%h exp=%h", alu_out, 32'd12); end
    checks++;
    if ({reg_write_en, rd_addr, wb_value_select, bj_sig} !== {1'b1, 5'd3, 2'b01, 1'b0}) begin
      failures++;
      $display("FAIL add_ctrl got we=%b rd=%0d wb=%b bj=%b exp we=1 rd=3 wb=01 bj=0",
               reg_write_en, rd_addr, wb_value_select, bj_sig);
    end
    checks++;
    if ({pc_plus_4, store_data} !== {32'h44, 32'd7}) begin
      failures++;
      $display("FAIL add_pc4_sd got pc4=%h sd=%h exp pc4=00000044 sd=00000007", pc_plus_4, store_data);
    end
  endtask

  task automatic test_sub_sra_slt();
    drive(32'h402081B3, 32'h0, 32'h8000_0000, 32'd1, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sub got=%h exp=7fffffff", alu_out); end
    drive(32'h4020D1B3, 32'h0, 32'h8000_0000, 32'd1, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'hC000_0000) begin failures++; $display("FAIL sra got=%h exp=c0000000", alu_out); end
    drive(32'h0020A1B3, 32'h0, 32'h8000_0000, 32'd1, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'd1) begin failures++; $display("FAIL slt got=%h exp=00000001", alu_out); end
    drive(32'h0020B1B3, 32'h0, 32'h8000_0000, 32'd1, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'd0) begin failures++; $display("FAIL sltu got=%h exp=00000000", alu_out); end
  endtask

  task automatic test_mext();
    drive(32'h022091B3, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'd0) begin failures++; $display("FAIL mulh got=%h exp=00000000", alu_out); end
    drive(32'h0220B1B3, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu got=%h exp=fffffffe", alu_out); end
    drive(32'h022081B3, 32'h0, 32'd6, 32'd7, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'd42) begin failures++; $display("FAIL mul got=%h exp=0000002a", alu_out); end
    drive(32'h0220C1B3, 32'h0, 32'd7, 32'd0, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_by_zero got=%h exp=ffffffff", alu_out); end
    drive(32'h0220E1B3, 32'h0, 32'd7, 32'd0, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'd7) begin failures++; $display("FAIL rem_by_zero got=%h exp=00000007", alu_out); end
    drive(32'h0220C1B3, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'h8000_0000) begin failures++; $display("FAIL div_overflow got=%h exp=80000000", alu_out); end
    drive(32'h0220E1B3, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'd0) begin failures++; $display("FAIL rem_overflow got=%h exp=00000000", alu_out); end
    drive(32'h0220C1B3, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg7_2 got=%h exp=fffffffd", alu_out); end
    drive(32'h0220E1B3, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'd0);
    tick();
    checks++;
    if (alu_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_neg7_2 got=%h exp=ffffffff", alu_out); end
  endtask

  task automatic test_branches();
    drive(32'h00208063, 32'h100, 32'd9, 32'd9, 32'h20);
    checks++;
    if (immediate_select !== 3'b010) begin failures++; $display("FAIL beq_immsel got=%b exp=010", immediate_select); end
    tick();
    checks++;
    if ({bj_sig, alu_out, reg_write_en} !== {1'b1, 32'h120, 1'b0}) begin
      failures++;
      $display("FAIL beq_taken got bj=%b alu=%h we=%b exp bj=1 alu=00000120 we=0", bj_sig, alu_out, reg_write_en);
    end
    drive(32'h00209063, 32'h100, 32'd9, 32'd9, 32'h20);
    tick();
    checks++;
    if (bj_sig !== 1'b0) begin failures++; $display("FAIL bne_not_taken got=%b exp=0", bj_sig); end
    drive(32'h0020C063, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    tick();
    checks++;
    if (bj_sig !== 1'b1) begin failures++; $display("FAIL blt_taken got=%b exp=1", bj_sig); end
    drive(32'h0020E063, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    tick();
    checks++;
    if (bj_sig !== 1'b0) begin failures++; $display("FAIL bltu_not_taken got=%b exp=0", bj_sig); end
  endtask

  task automatic test_jalr();
    drive(32'h004080E7, 32'h200, 32'h1001, 32'd0, 32'd4);
    checks++;
    if (immediate_select !== 3'b000) begin failures++; $display("FAIL jalr_immsel got=%b exp=000", immediate_select); end
    tick();
    checks++;
    if ({alu_out, bj_sig, wb_value_select, pc_plus_4, reg_write_en, rd_addr}
        !== {32'h1004, 1'b1, 2'b00, 32'h204, 1'b1, 5'd1}) begin
      failures++;
      $display("FAIL jalr got alu=%h bj=%b wb=%b pc4=%h we=%b rd=%0d exp alu=00001004 bj=1 wb=00 pc4=00000204 we=1 rd=1",
               alu_out, bj_sig, wb_value_select, pc_plus_4, reg_write_en, rd_addr);
    end
  endtask

  task automatic test_mem();
    drive(32'h0040A183, 32'h0, 32'h1000, 32'd0, 32'd4);
    tick();
    checks++;
    if ({data_mem_read, wb_value_select, reg_write_en, data_mem_write, alu_out}
        !== {4'b1010, 2'b10, 1'b1, 3'b000, 32'h1004}) begin
      failures++;
      $display("FAIL lw got rd=%b wb=%b we=%b wr=%b alu=%h exp rd=1010 wb=10 we=1 wr=000 alu=00001004",
               data_mem_read, wb_value_select, reg_write_en, data_mem_write, alu_out);
    end
    drive(32'h0020A423, 32'h0, 32'h2000, 32'hDEAD_BEEF, 32'd8);
    checks++;
    if (immediate_select !== 3'b001) begin failures++; $display("FAIL sw_immsel got=%b exp=001", immediate_select); end
    tick();
    checks++;
    if ({data_mem_write, reg_write_en, data_mem_read, store_data, alu_out}
        !== {3'b110, 1'b0, 4'b0000, 32'hDEAD_BEEF, 32'h2008}) begin
      failures++;
      $display("FAIL sw got wr=%b we=%b rd=%b sd=%h alu=%h exp wr=110 we=0 rd=0000 sd=deadbeef alu=00002008",
               data_mem_write, reg_write_en, data_mem_read, store_data, alu_out);
    end
  endtask

  task automatic test_lui();
    drive(32'h123452B7, 32'h300, 32'hAAAA_AAAA, 32'h5555_5555, 32'h1234_5000);
    checks++;
    if (immediate_select !== 3'b011) begin failures++; $display("FAIL lui_immsel got=%b exp=011", immediate_select); end
    tick();
    checks++;
    if ({alu_out, rd_addr, wb_value_select, reg_write_en} !== {32'h1234_5000, 5'd5, 2'b01, 1'b1}) begin
      failures++;
      $display("FAIL lui got alu=%h rd=%0d wb=%b we=%b exp alu=12345000 rd=5 wb=01 we=1",
               alu_out, rd_addr, wb_value_select, reg_write_en);
    end
  endtask

  task automatic test_hold();
    drive(32'h002081B3, 32'h40, 32'd5, 32'd7, 32'd0);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0020A423, 32'h1000 + 32'(i), 32'h2000, $urandom_range(100, 1000), 32'd8);
      tick();
      checks++;
      if ({alu_out, reg_write_en, rd_addr, store_data, pc_plus_4, data_mem_write}
          !== {32'd12, 1'b1, 5'd3, 32'd7, 32'h44, 3'b000}) begin
        failures++;
        $display("FAIL hold_cycle%0d got alu=%h we=%b rd=%0d sd=%h pc4=%h wr=%b exp alu=0000000c we=1 rd=3 sd=00000007 pc4=00000044 wr=000",
                 i, alu_out, reg_write_en, rd_addr, store_data, pc_plus_4, data_mem_write);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({alu_out, reg_write_en, rd_addr, store_data, pc_plus_4} !== '0) begin
      failures++;
      $display("FAIL reset_over_hold got alu=%h we=%b rd=%0d sd=%h pc4=%h exp all zero",
               alu_out, reg_write_en, rd_addr, store_data, pc_plus_4);
    end
    reset = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic test_nop();
    drive(32'h0000007F, 32'h0, 32'd3, 32'd4, 32'hFFFF_FFFF);
    checks++;
    if (immediate_select !== 3'b000) begin failures++; $display("FAIL nop_immsel got=%b exp=000", immediate_select); end
    tick();
    checks++;
    if ({bj_sig, reg_write_en, data_mem_write, data_mem_read, wb_value_select} !== '0) begin
      failures++;
      $display("FAIL nop_7f got bj=%b we=%b wr=%b rd=%b wb=%b exp all zero",
               bj_sig, reg_write_en, data_mem_write, data_mem_read, wb_value_select);
    end
    drive(32'h0000_0000, 32'h0, 32'd3, 32'd4, 32'hFFFF_FFFF);
    tick();
    checks++;
    if ({bj_sig, reg_write_en, data_mem_write, data_mem_read, wb_value_select} !== '0) begin
      failures++;
      $display("FAIL nop_zero got bj=%b we=%b wr=%b rd=%b wb=%b exp all zero",
               bj_sig, reg_write_en, data_mem_write, data_mem_read, wb_value_select);
    end
  endtask

  // Sequence of scenarios and final report
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    hold     = 1'b0;
    test_reset();
    test_add();
    test_sub_sra_slt();
    test_mext();
    test_branches();
    test_jalr();
    test_mem();
    test_lui();
    test_hold();
    test_nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
